// File: rtl/wind_lights.sv
// Wind/hazard lamp driver: calm, rotate right-to-left, rotate left-to-right and bounce modes with a built-in step prescaler.
// Optional build macro WIND_LIGHTS_PAUSE_EN adds a pause input that freezes the whole block.
module wind_lights #(
    parameter int NUM_LIGHTS = 3,
    parameter int TICK_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            wind,
`ifdef WIND_LIGHTS_PAUSE_EN
    input  logic                  pause,
`endif
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  step,
    output logic [1:0]            mode
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] WIND_CALM   = 2'b00;
    localparam logic [1:0] WIND_RTL    = 2'b01;
    localparam logic [1:0] WIND_LTR    = 2'b10;
    localparam logic [1:0] WIND_BOUNCE = 2'b11;

    function automatic logic [NUM_LIGHTS-1:0] alt_pattern(input int phase);
        logic [NUM_LIGHTS-1:0] r;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            r[i] = ((i % 2) == phase);
        end
        return r;
    endfunction

    localparam logic [NUM_LIGHTS-1:0] EVEN   = alt_pattern(0);
    localparam logic [NUM_LIGHTS-1:0] ODD    = alt_pattern(1);
    localparam logic [NUM_LIGHTS-1:0] ONE_LO = NUM_LIGHTS'(1);
    localparam logic [NUM_LIGHTS-1:0] ONE_HI = {1'b1, {(NUM_LIGHTS-1){1'b0}}};

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t                  dir;
    dir_t                  dir_next;
    logic [CW-1:0]         cnt;
    logic [NUM_LIGHTS-1:0] lights_next;
    logic [NUM_LIGHTS-1:0] shift_up;
    logic [NUM_LIGHTS-1:0] shift_down;
    logic [1:0]            mode_next;
    logic                  run;
    logic                  tick;

`ifdef WIND_LIGHTS_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    // While paused the prescaler holds, so no tick can fire and wind is never sampled.
    assign tick = run && (cnt == CNT_LAST);

    assign shift_up   = {lights[NUM_LIGHTS-2:0], 1'b0};
    assign shift_down = {1'b0, lights[NUM_LIGHTS-1:1]};

    always_comb begin
        lights_next = lights;
        dir_next    = dir;
        mode_next   = mode;
        if (tick) begin
            if (wind != mode) begin
                // Mode change loads the new mode's start pattern instead of advancing.
                mode_next = wind;
                case (wind)
                    WIND_CALM:   lights_next = EVEN;
                    WIND_RTL:    lights_next = ONE_LO;
                    WIND_LTR:    lights_next = ONE_HI;
                    WIND_BOUNCE: begin
                        lights_next = ONE_LO;
                        dir_next    = DIR_UP;
                    end
                    default:     lights_next = EVEN;
                endcase
            end else begin
                case (mode)
                    WIND_CALM:   lights_next = (lights == ODD) ? EVEN : ODD;
                    WIND_RTL:    lights_next = {lights[NUM_LIGHTS-2:0], lights[NUM_LIGHTS-1]};
                    WIND_LTR:    lights_next = {lights[0], lights[NUM_LIGHTS-1:1]};
                    WIND_BOUNCE: begin
                        // Direction flips on the step that lands on an end lamp, so ends are not repeated.
                        if (dir == DIR_UP) begin
                            lights_next = shift_up;
                            if (shift_up[NUM_LIGHTS-1]) dir_next = DIR_DOWN;
                        end else begin
                            lights_next = shift_down;
                            if (shift_down[0]) dir_next = DIR_UP;
                        end
                    end
                    default:     lights_next = EVEN;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            lights <= EVEN;
            mode   <= WIND_CALM;
            dir    <= DIR_UP;
            step   <= 1'b0;
        end else begin
            step   <= tick;
            lights <= lights_next;
            mode   <= mode_next;
            dir    <= dir_next;
            if (run) begin
                cnt <= tick ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule
